sha256_id_issuer: RTL and testbench

Controller that allocates message IDs for the SHA-256 accelerator and sequences their entry into the ID buffer. It round-robin arbitrates between NUM_REQ message sources and assigns each granted message the next sequential, wrapping ID. It pushes the ID and its last flag into the ID buffer over a valid/ready link, and caps in-flight IDs at MAX_OUTSTANDING using retire pulses from the validator. It sits between the message-source front end and the ID buffer input.

---
 rtl/sha256_id_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/sha256_id_issuer.sv | 84 ++++++++
 tb/tb_sha256_id_issuer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_id_pkg.sv
// sha256_id_pkg: shared types and defaults for the SHA-256 ID issuer and ID buffer
package sha256_id_pkg;
   localparam int ID_DATA_W_DEF = 6;
   typedef enum logic {IDLE, PUSH} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, highest priority at ptr
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);
   logic [2*NUM_REQ-1:0] rot;
   always_comb begin
      rot = {req, req} >> ptr;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (rot[i]) idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      any = |req;
      gnt = any ? (NUM_REQ'(1) << idx) : '0;
   end
endmodule

// File: rtl/sha256_id_issuer.sv
// sha256_id_issuer: round-robin ID allocator pushing IDs into the SHA-256 ID buffer
module sha256_id_issuer
   import sha256_id_pkg::*;
#(
   parameter int ID_DATA_W = ID_DATA_W_DEF,
   parameter int NUM_REQ = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 sync_rst,
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [ID_DATA_W-1:0] req_id,
   output logic [ID_DATA_W-1:0] buf_id,
   output logic                 buf_id_last,
   output logic                 buf_id_valid,
   input  logic                 buf_id_ready,
   input  logic                 retire,
   output logic [CNT_W-1:0]     status_outstanding,
   output logic [ID_DATA_W-1:0] status_next_id,
   output logic                 err_underflow
);
   localparam int IDX_W = $clog2(NUM_REQ);
   state_t state, state_nx;
   logic [NUM_REQ-1:0] gnt, win_gnt;
   logic [IDX_W-1:0] rr_ptr, gnt_idx, win_idx;
   logic any, grant, hs, drop;
   logic [CNT_W-1:0] outstanding;
   logic [ID_DATA_W-1:0] next_id;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(gnt),
      .idx(gnt_idx),
      .any(any)
   );

   // the cap uses the registered count, so a retire frees its slot one cycle later
   assign grant = en && state == IDLE && any && outstanding < CNT_W'(MAX_OUTSTANDING);
   assign hs = en && state == PUSH && buf_id_ready;
   assign drop = en && retire && outstanding != '0;

   always_ff @(posedge clk)
      state <= sync_rst ? IDLE : state_nx;

   always_comb
      state_nx = grant ? PUSH : hs ? IDLE : state;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         win_gnt <= '0;
         win_idx <= '0;
         rr_ptr <= '0;
         buf_id <= '0;
         buf_id_last <= 1'b0;
         next_id <= '0;
         outstanding <= '0;
         err_underflow <= 1'b0;
      end else if (en) begin
         if (grant) begin
            win_gnt <= gnt;
            win_idx <= gnt_idx;
            buf_id <= next_id;
            buf_id_last <= req_last[gnt_idx];
         end
         if (hs) begin
            next_id <= next_id + 1'b1;
            rr_ptr <= win_idx == IDX_W'(NUM_REQ - 1) ? '0 : win_idx + 1'b1;
         end
         outstanding <= outstanding + CNT_W'(hs) - CNT_W'(drop);
         if (retire && outstanding == '0) err_underflow <= 1'b1;
      end
   end

   assign buf_id_valid = state == PUSH;
   assign req_ready = hs ? win_gnt : '0;
   assign req_id = buf_id;
   assign status_outstanding = outstanding;
   assign status_next_id = next_id;
endmodule

// File: tb/tb_sha256_id_issuer.sv
// tb_sha256_id_issuer: vector table, directed corner cases and random run against a reference model
module tb_sha256_id_issuer;
   localparam int NREQ = 2;
   localparam int MAXO = 4;
   localparam int W = 6;
   localparam int CW = 3;

   logic clk, sync_rst, en, buf_id_ready, retire;
   logic [NREQ-1:0] req_valid, req_last, req_ready;
   logic [W-1:0] req_id, buf_id, status_next_id;
   logic buf_id_last, buf_id_valid, err_underflow;
   logic [CW-1:0] status_outstanding;

   sha256_id_issuer #(.ID_DATA_W(W), .NUM_REQ(NREQ), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
      .clk(clk),
      .sync_rst(sync_rst),
      .en(en),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_ready(req_ready),
      .req_id(req_id),
      .buf_id(buf_id),
      .buf_id_last(buf_id_last),
      .buf_id_valid(buf_id_valid),
      .buf_id_ready(buf_id_ready),
      .retire(retire),
      .status_outstanding(status_outstanding),
      .status_next_id(status_next_id),
      .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int rst, en, rv, rl, br, ret, chk;
      int e_v, e_rdy, e_id, e_last, e_out, e_nid, e_err;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int m_next, m_out, m_ptr, m_src, m_id;
   bit m_busy, m_last, m_err;
   int e_ready;
   logic [NREQ-1:0] dut_ready;
   logic [W-1:0] dut_rid;
   logic [NREQ-1:0] acked, src_v, src_l;
   vec_t tbl[26];
   int k;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // transaction-level reference: one pending push, a free-running ID and an in-flight count
   task automatic model_tick();
      int o;
      bit h;
      bit found;
      o = m_out;
      h = m_busy && buf_id_ready;
      if (sync_rst) begin
         m_busy = 0; m_id = 0; m_last = 0; m_src = 0;
         m_next = 0; m_out = 0; m_ptr = 0; m_err = 0;
      end else if (en) begin
         if (!m_busy && o < MAXO && req_valid != 0) begin
            found = 0;
            for (int j = 0; j < NREQ; j++)
               if (!found && req_valid[(m_ptr + j) % NREQ]) begin
                  found = 1;
                  m_src = (m_ptr + j) % NREQ;
               end
            m_id = m_next;
            m_last = req_last[m_src];
            m_busy = 1;
         end else if (h) begin
            m_next = (m_next + 1) % (1 << W);
            m_ptr = (m_src + 1) % NREQ;
            m_busy = 0;
         end
         m_out = o + int'(h) - int'(retire && o > 0);
         if (retire && o == 0) m_err = 1;
      end
   endtask

   task automatic sample(input bit use_model);
      @(negedge clk);
      e_ready = (en && m_busy && buf_id_ready) ? (1 << m_src) : 0;
      acked = NREQ'(e_ready);
      dut_ready = req_ready;
      dut_rid = req_id;
      if (use_model) begin
         chk("buf_id_valid", 32'(buf_id_valid), 32'(m_busy));
         chk("buf_id", 32'(buf_id), m_id);
         chk("buf_id_last", 32'(buf_id_last), 32'(m_last));
         chk("req_ready", 32'(req_ready), e_ready);
         chk("req_id", 32'(req_id), m_id);
         chk("status_outstanding", 32'(status_outstanding), m_out);
         chk("status_next_id", 32'(status_next_id), m_next);
         chk("err_underflow", 32'(err_underflow), 32'(m_err));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic do_reset();
      sync_rst = 1; en = 1; req_valid = '0; req_last = '0; buf_id_ready = 0; retire = 0;
      sample(0);
      tick();
      sync_rst = 0;
   endtask

   initial begin
      m_next = 0; m_out = 0; m_ptr = 0; m_src = 0; m_id = 0;
      m_busy = 0; m_last = 0; m_err = 0;
      sync_rst = 1; en = 1; req_valid = '0; req_last = '0; buf_id_ready = 0; retire = 0;
      // rst en rv rl br ret chk | valid ready id last out nid err
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 1, 1, 0, 1,  1, 1, 0, 1, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 1, 0, 1,  0, 0, 0, 1, 1, 1, 0};
      tbl[4]  = '{0, 1, 2, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1, 0};
      for (int i = 5; i < 10; i++)
         tbl[i] = '{0, 1, 2, 0, 0, 0, 1,  1, 0, 1, 0, 1, 1, 0};
      tbl[10] = '{0, 1, 2, 0, 1, 0, 1,  1, 2, 1, 0, 1, 1, 0};
      tbl[11] = '{0, 1, 0, 0, 1, 0, 1,  0, 0, 1, 0, 2, 2, 0};
      tbl[12] = '{0, 1, 0, 0, 1, 1, 1,  0, 0, 1, 0, 2, 2, 0};
      tbl[13] = '{0, 1, 0, 0, 1, 1, 1,  0, 0, 1, 0, 1, 2, 0};
      tbl[14] = '{0, 1, 0, 0, 1, 1, 1,  0, 0, 1, 0, 0, 2, 0};
      tbl[15] = '{0, 1, 0, 0, 1, 0, 1,  0, 0, 1, 0, 0, 2, 1};
      tbl[16] = '{0, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 0, 2, 1};
      tbl[17] = '{0, 1, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 2, 1};
      tbl[18] = '{0, 0, 1, 0, 1, 0, 1,  1, 0, 2, 0, 0, 2, 1};
      tbl[19] = '{0, 1, 1, 0, 1, 0, 1,  1, 1, 2, 0, 0, 2, 1};
      tbl[20] = '{0, 0, 0, 0, 1, 1, 1,  0, 0, 2, 0, 1, 3, 1};
      tbl[21] = '{0, 1, 0, 0, 1, 0, 1,  0, 0, 2, 0, 1, 3, 1};
      tbl[22] = '{0, 1, 1, 1, 0, 0, 1,  0, 0, 2, 0, 1, 3, 1};
      tbl[23] = '{0, 1, 1, 1, 0, 0, 1,  1, 0, 3, 1, 1, 3, 1};
      tbl[24] = '{1, 1, 1, 1, 0, 0, 1,  1, 0, 3, 1, 1, 3, 1};
      tbl[25] = '{0, 1, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 26; i++) begin
         sync_rst = tbl[i].rst != 0;
         en = tbl[i].en != 0;
         req_valid = NREQ'(tbl[i].rv);
         req_last = NREQ'(tbl[i].rl);
         buf_id_ready = tbl[i].br != 0;
         retire = tbl[i].ret != 0;
         sample(0);
         if (tbl[i].chk != 0) begin
            chk("vec_valid", 32'(buf_id_valid), tbl[i].e_v);
            chk("vec_ready", 32'(req_ready), tbl[i].e_rdy);
            chk("vec_buf_id", 32'(buf_id), tbl[i].e_id);
            chk("vec_req_id", 32'(req_id), tbl[i].e_id);
            chk("vec_last", 32'(buf_id_last), tbl[i].e_last);
            chk("vec_outstanding", 32'(status_outstanding), tbl[i].e_out);
            chk("vec_next_id", 32'(status_next_id), tbl[i].e_nid);
            chk("vec_err", 32'(err_underflow), tbl[i].e_err);
         end
         tick();
      end

      // round-robin with both sources held, retire alongside each later handshake
      do_reset();
      req_valid = 2'b11; req_last = 2'b10; buf_id_ready = 1; k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         retire = m_busy && m_out > 0;
         sample(1);
         if (dut_ready != 0) begin
            chk("rr_grant", 32'(dut_ready), (k % 2 == 0) ? 1 : 2);
            chk("rr_id", 32'(dut_rid), k);
            k++;
         end
         tick();
      end
      chk("rr_count", k, 4);
      retire = 0; req_valid = '0;
      sample(1);
      chk("rr_outstanding", 32'(status_outstanding), 1);
      tick();

      // outstanding cap, then a single retire releases the stalled request
      do_reset();
      req_valid = 2'b01; req_last = '0; buf_id_ready = 1; k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         sample(1);
         if (dut_ready != 0) k++;
         tick();
      end
      chk("cap_count", k, 4);
      for (int c = 0; c < 6; c++) begin
         sample(1);
         chk("cap_stall_ready", 32'(dut_ready), 0);
         chk("cap_stall_valid", 32'(buf_id_valid), 0);
         chk("cap_outstanding", 32'(status_outstanding), 4);
         tick();
      end
      retire = 1;
      sample(1);
      tick();
      retire = 0;
      sample(1);
      chk("cap_wait", 32'(dut_ready), 0);
      tick();
      sample(1);
      chk("cap_grant", 32'(dut_ready), 1);
      chk("cap_id", 32'(dut_rid), 4);
      tick();

      // ID wrap over 65 issues
      do_reset();
      req_valid = 2'b01; buf_id_ready = 1; k = 0;
      for (int c = 0; c < 200 && k < 65; c++) begin
         retire = m_busy && m_out > 0;
         sample(1);
         if (dut_ready != 0) begin
            if (k == 63) chk("wrap_id63", 32'(dut_rid), 63);
            if (k == 64) chk("wrap_id0", 32'(dut_rid), 0);
            k++;
         end
         tick();
      end
      chk("wrap_count", k, 65);

      // random traffic with protocol-abiding sources
      do_reset();
      src_v = '0; src_l = '0; acked = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (acked[i]) src_v[i] = 1'b0;
            if (!src_v[i] && $urandom_range(2) == 0) begin
               src_v[i] = 1'b1;
               src_l[i] = 1'($urandom_range(1));
            end
         end
         req_valid = src_v;
         req_last = src_l;
         buf_id_ready = $urandom_range(9) < 7;
         retire = $urandom_range(9) < 3;
         en = $urandom_range(19) != 0;
         sync_rst = $urandom_range(299) == 0;
         sample(1);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
